// File: rtl/serial_add_sub_if.sv
// ============================================================================
// Module   : serial_add_sub_if
// Purpose  : start/done handshake and operand/result bundle for serial_add_sub
// Revision : 1.0
// ============================================================================
`default_nettype none

interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

`default_nettype wire

// File: rtl/serial_add_sub.sv
// ============================================================================
// Module   : serial_add_sub
// Purpose  : bit-serial adder/subtractor, one full-adder cell reused LSB first
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  serial_add_sub_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic             r_carry_out;
  logic             r_overflow;

  logic w_sum;
  logic w_cout;
  logic w_last;

  assign w_sum  = r_sh_a[0] ^ r_sh_b[0] ^ r_carry;
  assign w_cout = (r_sh_a[0] & r_sh_b[0]) | (r_sh_a[0] & r_carry) | (r_sh_b[0] & r_carry);
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
            r_sh_a      <= bus.a;
            r_sh_b      <= bus.op_sub ? ~bus.b : bus.b;
            r_carry     <= bus.op_sub;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= {w_sum, r_result[WIDTH-1:1]};
          r_sh_a   <= r_sh_a >> 1;
          r_sh_b   <= r_sh_b >> 1;
          r_carry  <= w_cout;
          if (w_last) begin
            // r_carry here is the carry into the MSB; flags are registered
            // now so they are already valid during the DONE cycle.
            r_carry_out <= w_cout;
            r_overflow  <= w_cout ^ r_carry;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub.sv
// ============================================================================
// Module   : tb_serial_add_sub
// Purpose  : directed and exhaustive bench for serial_add_sub (WIDTH 8 and 4)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_add_sub;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  serial_add_sub_if #(.WIDTH(8)) if8 ();
  serial_add_sub_if #(.WIDTH(4)) if4 ();

  serial_add_sub #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_add_sub #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  // Index 0 is the 8-bit instance, index 1 the 4-bit instance.
  logic       start_v [2];
  logic       op_v    [2];
  logic [7:0] a_v     [2];
  logic [7:0] b_v     [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic       co_v    [2];
  logic       ov_v    [2];
  logic [7:0] res_v   [2];

  assign if8.start  = start_v[0];
  assign if8.op_sub = op_v[0];
  assign if8.a      = a_v[0];
  assign if8.b      = b_v[0];
  assign if4.start  = start_v[1];
  assign if4.op_sub = op_v[1];
  assign if4.a      = a_v[1][3:0];
  assign if4.b      = b_v[1][3:0];

  assign busy_v[0] = if8.busy;
  assign done_v[0] = if8.done;
  assign co_v[0]   = if8.carry_out;
  assign ov_v[0]   = if8.overflow;
  assign res_v[0]  = if8.result;
  assign busy_v[1] = if4.busy;
  assign done_v[1] = if4.done;
  assign co_v[1]   = if4.carry_out;
  assign ov_v[1]   = if4.overflow;
  assign res_v[1]  = {4'b0, if4.result};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  // Reference arithmetic on plain integers.
  function automatic void ref_calc(input int w, input int a, input int b, input bit op,
                                   output int r, output int co, output int ov);
    int m, s, sa, sb, tr;
    m  = 1 << w;
    a  = a % m;
    b  = b % m;
    s  = op ? (a + (m - 1 - b) + 1) : (a + b);
    r  = s % m;
    co = (s >= m) ? 1 : 0;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    tr = op ? (sa - sb) : (sa + sb);
    ov = (tr < -(m / 2) || tr >= m / 2) ? 1 : 0;
  endfunction

  task automatic check(input string nm, input int i, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s (w%0d) at %0t: got %0d expected %0d", nm, wid(i), $time, act, exp);
    end
  endtask

  // Timeline model: t = cycles since accepted start (1..W busy, W+1 done, 0 idle).
  int t   [2];
  int er  [2];
  int eco [2];
  int eov [2];
  int pr  [2];
  int pco [2];
  int pov [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        t[i] = 0; er[i] = 0; eco[i] = 0; eov[i] = 0;
      end else if (t[i] == 0) begin
        if (start_v[i]) begin
          t[i] = 1; er[i] = 0; eco[i] = 0; eov[i] = 0;
          ref_calc(wid(i), int'(a_v[i]), int'(b_v[i]), op_v[i], pr[i], pco[i], pov[i]);
        end
      end else if (t[i] <= wid(i)) begin
        t[i]++;
        if (t[i] == wid(i) + 1) begin
          er[i] = pr[i]; eco[i] = pco[i]; eov[i] = pov[i];
        end
      end else begin
        t[i] = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      check("busy", i, int'(busy_v[i]), (t[i] >= 1 && t[i] <= wid(i)) ? 1 : 0);
      check("done", i, int'(done_v[i]), (t[i] == wid(i) + 1) ? 1 : 0);
      check("carry_out", i, int'(co_v[i]), eco[i]);
      check("overflow", i, int'(ov_v[i]), eov[i]);
      if (t[i] == 0 || t[i] == wid(i) + 1)
        check("result", i, int'(res_v[i]), er[i]);
    end
  end

  task automatic do_op(input int i, input int a, input int b, input bit op,
                       input bit lit, input int xr, input int xco, input int xov);
    int seen;
    @(negedge clk);
    start_v[i] = 1'b1;
    a_v[i]     = 8'(a);
    b_v[i]     = 8'(b);
    op_v[i]    = op;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    a_v[i]     = 8'($urandom);
    b_v[i]     = 8'($urandom);
    op_v[i]    = 1'($urandom);
    seen = 0;
    for (int n = 1; n <= wid(i) + 4; n++) begin
      @(posedge clk);
      #1;
      if (done_v[i]) begin
        seen = n;
        break;
      end
    end
    check("latency", i, seen, wid(i));
    if (lit) begin
      check("lit_result", i, int'(res_v[i]), xr);
      check("lit_carry", i, int'(co_v[i]), xco);
      check("lit_ovf", i, int'(ov_v[i]), xov);
    end
    @(posedge clk);
  endtask

  initial begin
    int ndone;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; op_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
    end
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", 0, int'(busy_v[0]), 0);
    check("rst_done", 0, int'(done_v[0]), 0);
    check("rst_result", 0, int'(res_v[0]), 0);
    check("rst_carry", 0, int'(co_v[0]), 0);
    check("rst_ovf", 0, int'(ov_v[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 8'h25, 8'h13, 1'b0, 1'b1, 8'h38, 0, 0);
    do_op(0, 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1, 0);
    do_op(0, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 0, 1);
    do_op(0, 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 0, 0);
    do_op(0, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1, 1);
    do_op(0, 8'h33, 8'h33, 1'b1, 1'b1, 8'h00, 1, 0);

    // Continuous start: accepts at edges 0, 10, 20 -> three done pulses in 30 edges.
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 8'h01; b_v[0] = 8'h01; op_v[0] = 1'b0;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) begin
        ndone++;
        check("hold_result", 0, int'(res_v[0]), 8'h02);
      end
    end
    start_v[0] = 1'b0;
    check("hold_count", 0, ndone, 3);

    // Abort after three bits have been processed.
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 8'h55; b_v[0] = 8'h0F; op_v[0] = 1'b0;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 0, int'(busy_v[0]), 0);
    check("abort_done", 0, int'(done_v[0]), 0);
    check("abort_result", 0, int'(res_v[0]), 0);
    check("abort_carry", 0, int'(co_v[0]), 0);
    check("abort_ovf", 0, int'(ov_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 0, 0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int op = 0; op < 2; op++)
          do_op(1, a, b, op[0], 1'b0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
